div_issue_ctrl: RTL and testbench

- Sequential control stage wrapped around the combinational unsigned array divider (nbit_divider / div_block array).
- Accepts operand pairs over a valid/ready handshake and drives them into the array as registered, stable operands.
- Waits a parameterised number of settle cycles, because the array is a multicycle path, then captures quotient and remainder.
- Presents the result downstream over a valid/ready handshake; divide-by-zero is handled locally and never waits on the array.

---
 rtl/div_pkg.sv | 7 +
 rtl/div_settle_counter.sv | 18 +
 rtl/div_issue_ctrl.sv | 93 +++++++++
 tb/tb_div_issue_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and divide-by-zero quotient helper for div_issue_ctrl
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic logic [63:0] dz_quotient(input int width);
    return (width >= 64) ? {64{1'b1}} : (64'd1 << width) - 64'd1;
  endfunction
endpackage

// File: rtl/div_settle_counter.sv
// div_settle_counter: loadable down-counter timing the array's multicycle settle window
module div_settle_counter #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt,
  output logic          zero
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: handshake/settle controller around a combinational array divider
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_dz,
  output logic             busy
);
  localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 1");
  end
  state_t state, state_n;
  logic [WIDTH-1:0] div_a_n, div_b_n, out_q_n, out_r_n;
  logic out_valid_n, out_dz_n, accept, cnt_zero;
  logic [CW-1:0] cnt;
  assign in_ready = (state == IDLE) && !rst;
  assign accept = in_valid && in_ready;
  div_settle_counter #(.CW(CW)) u_cnt (
    .clk(clk),
    .rst(rst),
    .load(accept && in_b != '0),
    .dec(state == CALC),
    .load_val(CW'(SETTLE_CYCLES - 1)),
    .cnt(cnt),
    .zero(cnt_zero)
  );
  always_comb begin
    state_n = state;
    div_a_n = div_a;
    div_b_n = div_b;
    out_q_n = out_q;
    out_r_n = out_r;
    out_dz_n = out_dz;
    out_valid_n = out_valid;
    if (accept) begin
      div_a_n = in_a;
      div_b_n = in_b;
      if (in_b == '0) begin
        state_n = DONE;
        out_q_n = WIDTH'(dz_quotient(WIDTH));
        out_r_n = in_a;
        out_dz_n = 1'b1;
        out_valid_n = 1'b1;
      end else state_n = CALC;
    end else if (state == CALC && cnt_zero) begin
      state_n = DONE;
      out_q_n = div_q;
      out_r_n = div_r;
      out_dz_n = 1'b0;
      out_valid_n = 1'b1;
    end else if (state == DONE && out_ready) begin
      state_n = IDLE;
      out_valid_n = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      div_a <= '0;
      div_b <= '0;
      out_q <= '0;
      out_r <= '0;
      out_dz <= 1'b0;
      out_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      div_a <= div_a_n;
      div_b <= div_b_n;
      out_q <= out_q_n;
      out_r <= out_r_n;
      out_dz <= out_dz_n;
      out_valid <= out_valid_n;
      busy <= state_n != IDLE;
    end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed and randomized checks of div_issue_ctrl against an arithmetic model
module tb_div_issue_ctrl;
  localparam int W = 4;
  localparam int S = 2;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, out_dz, busy;
  logic [W-1:0] in_a = 0, in_b = 0, div_a, div_b, div_q, div_r, out_q, out_r;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  // behavioural array; deliberately returns junk on zero divisor, which the controller must ignore
  assign div_q = (div_b == 0) ? 4'hA : div_a / div_b;
  assign div_r = (div_b == 0) ? 4'h5 : div_a % div_b;
  div_issue_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .div_a(div_a), .div_b(div_b),
    .div_q(div_q), .div_r(div_r), .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .out_dz(out_dz), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input bit conc);
    int n;
    logic [W-1:0] eq, er;
    logic edz;
    edz = (b == 0);
    eq = edz ? 4'hF : a / b;
    er = edz ? a : a % b;
    in_a = a;
    in_b = b;
    in_valid = 1;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("accept_wait", n < 50, 1);
    tick();
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 50) begin
      chk("calc_in_ready", in_ready, 0);
      chk("calc_div_a", div_a, a);
      chk("calc_div_b", div_b, b);
      tick();
      n++;
    end
    chk("latency", n, edz ? 1 : S + 1);
    chk("q", out_q, eq);
    chk("r", out_r, er);
    chk("dz", out_dz, edz);
    chk("busy", busy, 1);
    if (conc) begin in_a = 5; in_b = 5; in_valid = 1; end
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_q", out_q, eq);
      chk("hold_r", out_r, er);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 1);
    chk("kept_q", out_q, eq);
  endtask
  initial begin
    logic [W-1:0] qa[$], qb[$];
    logic [W-1:0] a, b, pb;
    int accepts, cyc, last, got;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_div_a", div_a, 0);
    tick();
    rst = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_q", out_q, 0);
    run_op(13, 3, 0, 0);
    run_op(7, 0, 0, 0);
    run_op(9, 2, 6, 1);
    run_op(5, 5, 0, 0);
    run_op(2, 5, 0, 0);
    run_op(15, 1, 0, 0);
    run_op(0, 0, 0, 0);
    // reset mid-CALC must clear everything asynchronously and drop the result
    in_a = 11; in_b = 4; in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0;
    tick();
    #2 rst = 1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_q", out_q, 0);
    chk("arst_out_r", out_r, 0);
    chk("arst_div_a", div_a, 0);
    chk("arst_div_b", div_b, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    tick();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_stale_result", out_valid, 0);
    end
    run_op(11, 4, 0, 0);
    // streaming: accepts must be spaced S+2 cycles (2 after a zero divisor)
    accepts = 0; cyc = 0; last = -1; got = 0; pb = 0;
    a = W'($urandom); b = ($urandom % 4 == 0) ? 0 : W'($urandom_range(1, 15));
    in_a = a; in_b = b; in_valid = 1; out_ready = 1;
    while ((accepts < 20 || qa.size() != 0) && cyc < 1000) begin
      if (out_valid) begin
        chk("stream_has_pending", qa.size() != 0, 1);
        if (qa.size() != 0) begin
          chk("stream_dz", out_dz, qb[0] == 0);
          chk("stream_q", out_q, qb[0] == 0 ? 4'hF : qa[0] / qb[0]);
          chk("stream_r", out_r, qb[0] == 0 ? qa[0] : qa[0] % qb[0]);
          void'(qa.pop_front());
          void'(qb.pop_front());
          got++;
        end
      end
      if (in_ready && accepts < 20) begin
        if (last >= 0) chk("stream_spacing", cyc - last, pb == 0 ? 2 : S + 2);
        qa.push_back(a);
        qb.push_back(b);
        last = cyc;
        pb = b;
        accepts++;
      end
      tick();
      cyc++;
      if (accepts == 20) in_valid = 0;
      else if (last == cyc - 1) begin
        a = W'($urandom);
        b = ($urandom % 4 == 0) ? 0 : W'($urandom_range(1, 15));
        in_a = a;
        in_b = b;
      end
    end
    chk("stream_done", got, 20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
